// File: rtl/coverfloat_vector_packer.sv
// Pairs in-order operation requests with their responses and emits one packed cover vector per pair.
// Requests wait in a small FIFO until their response arrives, and the output register is valid/ready backpressured.
module coverfloat_vector_packer #(
  parameter int OP_W   = 32,
  parameter int RM_W   = 8,
  parameter int OPND_W = 128,
  parameter int FMT_W  = 8,
  parameter int EXC_W  = 8,
  parameter int INTX_W = 32,
  parameter int INTM_W = 192,
  parameter int DEPTH  = 4,
  localparam int CV_W  = OP_W + RM_W + 4*OPND_W + 2*FMT_W + EXC_W + 1 + INTX_W + INTM_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [RM_W-1:0]   req_rm,
  input  logic [OPND_W-1:0] req_a,
  input  logic [OPND_W-1:0] req_b,
  input  logic [OPND_W-1:0] req_c,
  input  logic [FMT_W-1:0]  req_operandFmt,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [OPND_W-1:0] rsp_result,
  input  logic [FMT_W-1:0]  rsp_resultFmt,
  input  logic [EXC_W-1:0]  rsp_exceptionBits,
  input  logic              rsp_intermS,
  input  logic [INTX_W-1:0] rsp_intermX,
  input  logic [INTM_W-1:0] rsp_intermM,
  output logic              cv_valid,
  input  logic              cv_ready,
  output logic [CV_W-1:0]   cv_data,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic [31:0]       vec_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REQ_W = OP_W + RM_W + 3*OPND_W + FMT_W;

  logic [REQ_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             cv_valid_r;
  logic [CV_W-1:0]  cv_data_r;
  logic [31:0]      vec_count_r;
  logic             push_s;
  logic             pop_s;

  // A full FIFO never accepts, even when it pops in the same cycle; the output slot must be free or draining to pop.
  assign req_ready   = rst_n && (cnt_r != CNT_W'(DEPTH));
  assign rsp_ready   = rst_n && (cnt_r != {CNT_W{1'b0}}) && (!cv_valid_r || cv_ready);
  assign push_s      = req_valid && req_ready;
  assign pop_s       = rsp_valid && rsp_ready;
  assign cv_valid    = cv_valid_r;
  assign cv_data     = cv_data_r;
  assign pending_cnt = cnt_r;
  assign vec_count   = vec_count_r;

  // Request storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {req_op, req_rm, req_a, req_b, req_c, req_operandFmt};
    end
  end

  // Pointers, occupancy, output vector register and emitted-vector counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      cv_valid_r  <= 1'b0;
      cv_data_r   <= {CV_W{1'b0}};
      vec_count_r <= 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (pop_s) begin
        cv_valid_r <= 1'b1;
        cv_data_r  <= {mem_r[rd_ptr_r], rsp_result, rsp_resultFmt, rsp_exceptionBits,
                       rsp_intermS, rsp_intermX, rsp_intermM};
      end else if (cv_ready) begin
        cv_valid_r <= 1'b0;
      end
      if (cv_valid_r && cv_ready) begin
        vec_count_r <= vec_count_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_coverfloat_vector_packer.sv
// Directed bench for coverfloat_vector_packer: reset, single pairing, fill, backpressure, orphan response,
// streaming and mid-operation reset, each scenario checking against hand-derived values.
module tb_coverfloat_vector_packer;

  localparam int CV_W = 801;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_op;
  logic [7:0]   req_rm;
  logic [127:0] req_a, req_b, req_c;
  logic [7:0]   req_operandFmt;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_result;
  logic [7:0]   rsp_resultFmt;
  logic [7:0]   rsp_exceptionBits;
  logic         rsp_intermS;
  logic [31:0]  rsp_intermX;
  logic [191:0] rsp_intermM;
  logic         cv_valid;
  logic         cv_ready;
  logic [CV_W-1:0] cv_data;
  logic [2:0]   pending_cnt;
  logic [31:0]  vec_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  coverfloat_vector_packer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rm(req_rm), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_operandFmt(req_operandFmt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_resultFmt(rsp_resultFmt),
    .rsp_exceptionBits(rsp_exceptionBits), .rsp_intermS(rsp_intermS),
    .rsp_intermX(rsp_intermX), .rsp_intermM(rsp_intermM),
    .cv_valid(cv_valid), .cv_ready(cv_ready), .cv_data(cv_data),
    .pending_cnt(pending_cnt), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  function automatic logic [CV_W-1:0] pack(
    input logic [31:0] op, input logic [7:0] rm, input logic [127:0] a, input logic [127:0] b,
    input logic [127:0] c, input logic [7:0] fmt, input logic [127:0] res, input logic [7:0] rfmt,
    input logic [7:0] exc, input logic s, input logic [31:0] x, input logic [191:0] m);
    return {op, rm, a, b, c, fmt, res, rfmt, exc, s, x, m};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_op = 32'h0; req_rm = 8'h0; req_a = 128'h0; req_b = 128'h0;
    req_c = 128'h0; req_operandFmt = 8'h0;
    rsp_valid = 1'b0; rsp_result = 128'h0; rsp_resultFmt = 8'h0; rsp_exceptionBits = 8'h0;
    rsp_intermS = 1'b0; rsp_intermX = 32'h0; rsp_intermM = 192'h0;
    cv_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    req_valid = 1'b1;
    rsp_valid = 1'b1;
    step();
    step();
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b expected 0", req_ready); else pass_cnt++;
    total_cnt++; if (rsp_ready !== 1'b0) $display("FAIL reset_rsp_ready: got %b expected 0", rsp_ready); else pass_cnt++;
    total_cnt++; if (pending_cnt !== 3'd0) $display("FAIL reset_pending: got %0d expected 0", pending_cnt); else pass_cnt++;
    total_cnt++; if (cv_valid !== 1'b0) $display("FAIL reset_cv_valid: got %b expected 0", cv_valid); else pass_cnt++;
    total_cnt++; if (cv_data !== {CV_W{1'b0}}) $display("FAIL reset_cv_data: got %h expected 0", cv_data); else pass_cnt++;
    total_cnt++; if (vec_count !== 32'd0) $display("FAIL reset_vec_count: got %0d expected 0", vec_count); else pass_cnt++;
    idle();
    rst_n = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL post_reset_req_ready: got %b expected 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    logic [CV_W-1:0] exp_v;
    exp_v = pack(32'h11, 8'h03, 128'h3F80_0000, 128'h5, 128'h7, 8'h01,
                 128'h4000_0000, 8'h01, 8'h10, 1'b1, 32'h7F, 192'hABCD);
    req_valid = 1'b1; req_op = 32'h11; req_rm = 8'h03; req_a = 128'h3F80_0000;
    req_b = 128'h5; req_c = 128'h7; req_operandFmt = 8'h01;
    step();
    req_valid = 1'b0;
    total_cnt++; if (pending_cnt !== 3'd1) $display("FAIL single_pending_push: got %0d expected 1", pending_cnt); else pass_cnt++;
    total_cnt++; if (cv_valid !== 1'b0) $display("FAIL single_cv_early: got %b expected 0", cv_valid); else pass_cnt++;
    rsp_valid = 1'b1; rsp_result = 128'h4000_0000; rsp_resultFmt = 8'h01; rsp_exceptionBits = 8'h10;
    rsp_intermS = 1'b1; rsp_intermX = 32'h7F; rsp_intermM = 192'hABCD; cv_ready = 1'b1;
    #1;
    total_cnt++; if (rsp_ready !== 1'b1) $display("FAIL single_rsp_ready: got %b expected 1", rsp_ready); else pass_cnt++;
    step();
    rsp_valid = 1'b0;
    total_cnt++; if (cv_valid !== 1'b1) $display("FAIL single_cv_valid: got %b expected 1", cv_valid); else pass_cnt++;
    total_cnt++; if (cv_data[800:769] !== 32'h11) $display("FAIL single_op_field: got %h expected 11", cv_data[800:769]); else pass_cnt++;
    total_cnt++; if (cv_data[760:633] !== 128'h3F80_0000) $display("FAIL single_a_field: got %h expected 3f800000", cv_data[760:633]); else pass_cnt++;
    total_cnt++; if (cv_data[368:241] !== 128'h4000_0000) $display("FAIL single_result_field: got %h expected 40000000", cv_data[368:241]); else pass_cnt++;
    total_cnt++; if (cv_data[224] !== 1'b1) $display("FAIL single_intermS_field: got %b expected 1", cv_data[224]); else pass_cnt++;
    total_cnt++; if (cv_data !== exp_v) $display("FAIL single_vector: got %h expected %h", cv_data, exp_v); else pass_cnt++;
    total_cnt++; if (pending_cnt !== 3'd0) $display("FAIL single_pending_pop: got %0d expected 0", pending_cnt); else pass_cnt++;
    step();
    total_cnt++; if (cv_valid !== 1'b0) $display("FAIL single_cv_clear: got %b expected 0", cv_valid); else pass_cnt++;
    total_cnt++; if (vec_count !== 32'd1) $display("FAIL single_vec_count: got %0d expected 1", vec_count); else pass_cnt++;
    idle();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_op = 32'h20 + 32'(i);
      #1;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL fill_ready_%0d: got %b expected 1", i, req_ready); else pass_cnt++;
      step();
    end
    req_op = 32'h55;
    #1;
    total_cnt++; if (pending_cnt !== 3'd4) $display("FAIL fill_pending: got %0d expected 4", pending_cnt); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL fill_req_ready: got %b expected 0", req_ready); else pass_cnt++;
    step();
    total_cnt++; if (pending_cnt !== 3'd4) $display("FAIL fill_fifth_rejected: got %0d expected 4", pending_cnt); else pass_cnt++;
    req_op = 32'h66; rsp_valid = 1'b1; cv_ready = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL fill_no_bypass_ready: got %b expected 0", req_ready); else pass_cnt++;
    step();
    idle();
    total_cnt++; if (pending_cnt !== 3'd3) $display("FAIL fill_pop_no_push: got %0d expected 3", pending_cnt); else pass_cnt++;
    total_cnt++; if (cv_data[800:769] !== 32'h20) $display("FAIL fill_head_op: got %h expected 20", cv_data[800:769]); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_backpressure();
    logic [CV_W-1:0] exp1, exp2;
    exp1 = pack(32'hA1, 8'h0, 128'h0, 128'h0, 128'h0, 8'h0, 128'h111, 8'h0, 8'h0, 1'b0, 32'h0, 192'h0);
    exp2 = pack(32'hA2, 8'h0, 128'h0, 128'h0, 128'h0, 8'h0, 128'h222, 8'h0, 8'h0, 1'b0, 32'h0, 192'h0);
    req_valid = 1'b1; req_op = 32'hA1;
    step();
    req_op = 32'hA2;
    step();
    req_valid = 1'b0;
    rsp_valid = 1'b1; rsp_result = 128'h111;
    step();
    rsp_result = 128'h222;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (rsp_ready !== 1'b0) $display("FAIL bp_rsp_ready_%0d: got %b expected 0", i, rsp_ready); else pass_cnt++;
      total_cnt++; if (cv_valid !== 1'b1 || cv_data !== exp1) $display("FAIL bp_hold_%0d: got %b/%h expected 1/%h", i, cv_valid, cv_data[800:769], exp1[800:769]); else pass_cnt++;
      step();
    end
    cv_ready = 1'b1;
    #1;
    total_cnt++; if (rsp_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", rsp_ready); else pass_cnt++;
    step();
    rsp_valid = 1'b0;
    total_cnt++; if (cv_valid !== 1'b1 || cv_data !== exp2) $display("FAIL bp_second: got %b/%h expected 1/%h", cv_valid, cv_data[800:769], exp2[800:769]); else pass_cnt++;
    step();
    total_cnt++; if (cv_valid !== 1'b0) $display("FAIL bp_clear: got %b expected 0", cv_valid); else pass_cnt++;
    total_cnt++; if (vec_count !== 32'd2) $display("FAIL bp_vec_count: got %0d expected 2", vec_count); else pass_cnt++;
    idle();
  endtask

  task automatic test_orphan();
    rsp_valid = 1'b1; cv_ready = 1'b1;
    #1;
    total_cnt++; if (rsp_ready !== 1'b0) $display("FAIL orphan_rsp_ready: got %b expected 0", rsp_ready); else pass_cnt++;
    step();
    step();
    total_cnt++; if (cv_valid !== 1'b0) $display("FAIL orphan_cv_valid: got %b expected 0", cv_valid); else pass_cnt++;
    total_cnt++; if (pending_cnt !== 3'd0 || vec_count !== 32'd2) $display("FAIL orphan_state: got %0d/%0d expected 0/2", pending_cnt, vec_count); else pass_cnt++;
    idle();
  endtask

  task automatic test_stream();
    logic [31:0] next_op, exp_op;
    int got, bad_op, over;
    logic fire;
    do_reset();
    next_op = 32'h100; exp_op = 32'h100; got = 0; bad_op = 0; over = 0;
    req_valid = 1'b1; rsp_valid = 1'b1; cv_ready = 1'b1; rsp_result = 128'h55;
    for (int k = 0; k < 100; k++) begin
      req_op = next_op;
      #1;
      fire = req_ready;
      if (cv_valid) begin
        if (cv_data[800:769] !== exp_op) begin
          bad_op++;
          if (bad_op == 1) $display("FAIL stream_op_order: got %h expected %h", cv_data[800:769], exp_op);
        end
        exp_op++;
        got++;
      end
      if (pending_cnt > 3'd4) over++;
      step();
      if (fire) next_op++;
    end
    total_cnt++; if (bad_op != 0) $display("FAIL stream_op_total: got %0d wrong ops expected 0", bad_op); else pass_cnt++;
    total_cnt++; if (got != 98) $display("FAIL stream_throughput: got %0d vectors expected 98", got); else pass_cnt++;
    total_cnt++; if (over != 0) $display("FAIL stream_pending_bound: got %0d overflows expected 0", over); else pass_cnt++;
    total_cnt++; if (vec_count !== 32'd98) $display("FAIL stream_vec_count: got %0d expected 98", vec_count); else pass_cnt++;
    req_valid = 1'b0; rsp_valid = 1'b0;
    #1;
    total_cnt++; if (cv_valid !== 1'b1 || cv_data[800:769] !== exp_op) $display("FAIL stream_last: got %b/%h expected 1/%h", cv_valid, cv_data[800:769], exp_op); else pass_cnt++;
    step();
    total_cnt++; if (cv_valid !== 1'b0 || vec_count !== 32'd99 || pending_cnt !== 3'd1) $display("FAIL stream_drain: got %b/%0d/%0d expected 0/99/1", cv_valid, vec_count, pending_cnt); else pass_cnt++;
    idle();
  endtask

  task automatic test_mid_reset();
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_op = 32'h300 + 32'(i);
      step();
    end
    req_valid = 1'b0; rsp_valid = 1'b1;
    step();
    rsp_valid = 1'b0;
    total_cnt++; if (pending_cnt !== 3'd3 || cv_valid !== 1'b1 || vec_count !== 32'd99) $display("FAIL midrst_pre: got %0d/%b/%0d expected 3/1/99", pending_cnt, cv_valid, vec_count); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (req_ready !== 1'b0 || rsp_ready !== 1'b0) $display("FAIL midrst_ready_low: got %b/%b expected 0/0", req_ready, rsp_ready); else pass_cnt++;
    step();
    rst_n = 1'b1;
    #1;
    total_cnt++; if (pending_cnt !== 3'd0) $display("FAIL midrst_pending: got %0d expected 0", pending_cnt); else pass_cnt++;
    total_cnt++; if (cv_valid !== 1'b0 || cv_data !== {CV_W{1'b0}}) $display("FAIL midrst_cv: got %b expected 0", cv_valid); else pass_cnt++;
    total_cnt++; if (vec_count !== 32'd0) $display("FAIL midrst_vec_count: got %0d expected 0", vec_count); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL midrst_req_ready: got %b expected 1", req_ready); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_orphan();
    test_stream();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
